// File: rtl/reg_bank_8x16_pkg.sv
// Shared definitions for the 8x16 writeback register bank.
package reg_bank_8x16_pkg;

  localparam int REG_COUNT      = 8;
  localparam int REG_IDX_W      = 3;
  localparam int DATA_W_DEFAULT = 16;
  localparam int ERR_CNT_W      = 4;
  localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = 4'd15;

  // Encode a one-hot strobe into a register index.
  // The result is meaningful only when exactly one bit is set.
  function automatic logic [REG_IDX_W-1:0] onehot_idx(input logic [REG_COUNT-1:0] vec);
    logic [REG_IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < REG_COUNT; i++) begin
      if (vec[i]) idx = idx | REG_IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/reg_bank_8x16_onehot_chk.sv
// Strobe legality check: classifies a decoder output as empty, one-hot,
// or carrying more than one set bit. Shared by every decoder consumer.
module onehot_chk
  import reg_bank_8x16_pkg::*;
(
  input  logic [REG_COUNT-1:0] vec,
  output logic                 none,
  output logic                 one,
  output logic                 multi
);

  // Clearing the lowest set bit leaves zero only for a power of two.
  always_comb begin
    none  = (vec == '0);
    one   = !none && ((vec & (vec - 1'b1)) == '0);
    multi = !none && !one;
  end

endmodule

// File: rtl/reg_bank_8x16.sv
// Eight-entry general-purpose register bank on the writeback path.
// One write port driven by a one-hot decoder strobe, two asynchronous read
// ports, and illegal-strobe monitoring (sticky flag + saturating count).
// Optional feature: define REG_BANK_BYPASS_EN for write-first forwarding
// of an in-flight legal write onto the read ports.
module reg_bank_8x16
  import reg_bank_8x16_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEFAULT,
  parameter bit R0_ZERO = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [REG_COUNT-1:0] wr_sel,
  input  logic [DATA_W-1:0]    wr_data,
  input  logic [REG_IDX_W-1:0] rd_addr_a,
  input  logic [REG_IDX_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0]    rd_data_a,
  output logic [DATA_W-1:0]    rd_data_b,
  input  logic                 clr_err,
  output logic                 sel_err,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  logic [DATA_W-1:0]    regs [REG_COUNT];
  logic                 strobe_none;
  logic                 strobe_one;
  logic                 strobe_multi;
  logic [REG_IDX_W-1:0] wr_idx;
  logic                 wr_en;

  onehot_chk u_onehot_chk (
    .vec   (wr_sel),
    .none  (strobe_none),
    .one   (strobe_one),
    .multi (strobe_multi)
  );

  // Decode the strobe into a single write enable; writes to a hardwired
  // register 0 are dropped silently and are not errors.
  always_comb begin
    wr_idx = onehot_idx(wr_sel);
    wr_en  = !strobe_none && strobe_one && !(R0_ZERO && (wr_idx == '0));
  end

  // Register array: only a legal one-hot strobe writes, exactly one entry.
  // NOTE: the array is cleared by async reset because downstream reads
  // must see 0 immediately after rst_n; this is affordable at 8 entries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
    end else begin
      for (int i = 0; i < REG_COUNT; i++) begin
        if (wr_en && (wr_idx == REG_IDX_W'(i))) regs[i] <= wr_data;
      end
    end
  end

  // Error monitor: clear wins over a simultaneous illegal strobe; the count
  // saturates instead of wrapping so a long burst is never mistaken for few.
  // NOTE: state updates use <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_err <= 1'b0;
      err_cnt <= '0;
    end else if (clr_err) begin
      sel_err <= 1'b0;
      err_cnt <= '0;
    end else if (strobe_multi) begin
      sel_err <= 1'b1;
      if (err_cnt != ERR_CNT_MAX) err_cnt <= err_cnt + 1'b1;
    end
  end

  // Asynchronous read ports, with optional forwarding and register-0 masking.
  // NOTE: each output gets a default first so no path infers a latch.
  always_comb begin
    rd_data_a = regs[rd_addr_a];
    rd_data_b = regs[rd_addr_b];
`ifdef REG_BANK_BYPASS_EN
    if (wr_en && (wr_idx == rd_addr_a)) rd_data_a = wr_data;
    if (wr_en && (wr_idx == rd_addr_b)) rd_data_b = wr_data;
`else
    // Same-cycle reads return the pre-write contents.
`endif
    if (R0_ZERO && (rd_addr_a == '0)) rd_data_a = '0;
    if (R0_ZERO && (rd_addr_b == '0)) rd_data_b = '0;
  end

endmodule
